tqvp_hx2003_pulse_job_scheduler: RTL and testbench

//  Queues transmit jobs and sequences the pulse transmitter: drives its start level and end count,

---
 rtl/tqvp_hx2003_pulse_job_scheduler_if.sv | 25 ++
 rtl/tqvp_hx2003_pulse_job_scheduler.sv | 169 ++++++++++++++++
 tb/tb_tqvp_hx2003_pulse_job_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_hx2003_pulse_job_scheduler_if.sv
// Job push handshake and pulse-transmitter control signals for the pulse job scheduler.
// The master side posts jobs and reports tx_done; the slave side is the scheduler.
interface tqvp_hx2003_pulse_job_scheduler_if #(
  parameter int REP_W = 4,
  parameter int GAP_W = 16
);
  logic             push_valid;
  logic             push_ready;
  logic [6:0]       push_end;
  logic [REP_W-1:0] push_rep;
  logic [GAP_W-1:0] push_gap;
  logic             tx_start;
  logic [6:0]       tx_end_count;
  logic             tx_done;

  modport master (
    output push_valid, push_end, push_rep, push_gap, tx_done,
    input  push_ready, tx_start, tx_end_count
  );

  modport slave (
    input  push_valid, push_end, push_rep, push_gap, tx_done,
    output push_ready, tx_start, tx_end_count
  );
endinterface

// File: rtl/tqvp_hx2003_pulse_job_scheduler.sv
// Queues pulse-transmit jobs and sequences the transmitter: launch, wait tx_done,
// idle gap, repeat N times, then move to the next queued job.
//  state | meaning
//  IDLE  | no active job; launch head of FIFO when enabled
//  RUN   | tx_start high, waiting for tx_done
//  GAP   | tx_start low, counting down the inter-transmission gap
module tqvp_hx2003_pulse_job_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 16,
  parameter int REP_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       abort,
  tqvp_hx2003_pulse_job_scheduler_if.slave job_if,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       job_done,
  output logic                       irq,
  input  logic                       irq_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q;
  logic               tx_start_q;
  logic [6:0]         tx_end_q;
  logic [REP_W-1:0]   rep_left_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [GAP_W-1:0]   gap_len_q;
  logic               job_done_q;
  logic               irq_q;

  logic [6:0]         end_mem_q [DEPTH];
  logic [REP_W-1:0]   rep_mem_q [DEPTH];
  logic [GAP_W-1:0]   gap_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic               full;
  logic               push_fire;
  logic               launch;
  logic [REP_W-1:0]   head_rep_eff;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign job_if.push_ready = !full && !abort;
  assign push_fire  = job_if.push_valid && job_if.push_ready;
  assign launch     = (state_q == S_IDLE) && enable && (count_q != '0) && !abort;

  // A zero repeat count still transmits once.
  assign head_rep_eff = (rep_mem_q[rd_ptr_q] == '0) ? REP_W'(1) : rep_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (abort) begin
      count_d = '0;
    end else if (push_fire && !launch) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_fire && launch) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      end_mem_q[wr_ptr_q] <= job_if.push_end;
      rep_mem_q[wr_ptr_q] <= job_if.push_rep;
      gap_mem_q[wr_ptr_q] <= job_if.push_gap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (launch)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_end_q   <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
      gap_len_q  <= '0;
      job_done_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      if (irq_clr) irq_q <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        tx_start_q <= 1'b0;
        rep_left_q <= '0;
        gap_cnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (launch) begin
              tx_start_q <= 1'b1;
              tx_end_q   <= end_mem_q[rd_ptr_q];
              rep_left_q <= head_rep_eff;
              gap_len_q  <= gap_mem_q[rd_ptr_q];
              state_q    <= S_RUN;
            end else begin
              tx_start_q <= 1'b0;
            end
          end
          S_RUN: begin
            tx_start_q <= 1'b1;
            if (job_if.tx_done) begin
              tx_start_q <= 1'b0;
              gap_cnt_q  <= gap_len_q;
              rep_left_q <= rep_left_q - REP_W'(1);
              state_q    <= S_GAP;
            end
          end
          S_GAP: begin
            tx_start_q <= 1'b0;
            if (gap_cnt_q != '0) begin
              gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end else if (rep_left_q != '0) begin
              tx_start_q <= 1'b1;
              state_q    <= S_RUN;
            end else begin
              // Setting irq overrides a same-cycle irq_clr.
              job_done_q <= 1'b1;
              if (count_q == '0) irq_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: begin
            tx_start_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign job_if.tx_start     = tx_start_q;
  assign job_if.tx_end_count = tx_end_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign job_done   = job_done_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_tqvp_hx2003_pulse_job_scheduler.sv
// Directed bench for the pulse job scheduler: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_tqvp_hx2003_pulse_job_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       abort;
  logic       irq_clr;
  logic       busy;
  logic [2:0] fifo_count;
  logic       job_done;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  logic tx_prev = 1'b0;

  tqvp_hx2003_pulse_job_scheduler_if jif ();

  tqvp_hx2003_pulse_job_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .abort      (abort),
    .job_if     (jif),
    .busy       (busy),
    .fifo_count (fifo_count),
    .job_done   (job_done),
    .irq        (irq),
    .irq_clr    (irq_clr)
  );

  always #5 clk = ~clk;

  // Rising edges of tx_start as the transmitter would see them.
  always @(negedge clk) begin
    if (jif.tx_start && !tx_prev) edges++;
    tx_prev = jif.tx_start;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [6:0] e, input logic [3:0] r, input logic [15:0] g);
    jif.push_valid = 1'b1;
    jif.push_end   = e;
    jif.push_rep   = r;
    jif.push_gap   = g;
    tick();
    jif.push_valid = 1'b0;
  endtask

  task automatic pulse_done;
    jif.tx_done = 1'b1;
    tick();
    jif.tx_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (jif.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %0d want 0", jif.tx_start); end
    n_checks++; if (jif.tx_end_count !== 7'd0) begin n_fail++; $display("FAIL reset_end_count: got %0d want 0", jif.tx_end_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_checks++; if (job_done !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_jd_irq: got %0d/%0d want 0/0", job_done, irq); end
    n_checks++; if (jif.push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %0d want 1", jif.push_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    enable = 1'b1;
    push_job(7'd5, 4'd1, 16'd3);
    n_checks++; if (jif.tx_start !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_latency1: got start=%0d cnt=%0d want 0/1", jif.tx_start, fifo_count); end
    tick();
    n_checks++; if (jif.tx_start !== 1'b1 || jif.tx_end_count !== 7'd5) begin n_fail++; $display("FAIL single_launch: got start=%0d end=%0d want 1/5", jif.tx_start, jif.tx_end_count); end
    n_checks++; if (busy !== 1'b1 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_busy: got busy=%0d cnt=%0d want 1/0", busy, fifo_count); end
    pulse_done();
    n_checks++; if (jif.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_stop: got %0d want 0", jif.tx_start); end
    repeat (3) tick();
    n_checks++; if (job_done !== 1'b0 || busy !== 1'b1 || jif.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_gap: got jd=%0d busy=%0d start=%0d want 0/1/0", job_done, busy, jif.tx_start); end
    tick();
    n_checks++; if (job_done !== 1'b1 || irq !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got jd=%0d irq=%0d busy=%0d want 1/1/0", job_done, irq, busy); end
    tick();
    n_checks++; if (job_done !== 1'b0 || jif.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_after: got jd=%0d start=%0d want 0/0", job_done, jif.tx_start); end
  endtask

  task automatic test_repeat;
    int low;
    int t;
    edges = 0;
    push_job(7'd9, 4'd3, 16'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse_done();
      low = 0;
      while (!jif.tx_start && !job_done && low < 20) begin
        low++;
        tick();
      end
      n_checks++; if (low !== 1) begin n_fail++; $display("FAIL repeat_low_%0d: got %0d cycles want 1", i, low); end
      if (i < 2) begin
        n_checks++; if (jif.tx_start !== 1'b1) begin n_fail++; $display("FAIL repeat_relaunch_%0d: got %0d want 1", i, jif.tx_start); end
      end else begin
        n_checks++; if (job_done !== 1'b1) begin n_fail++; $display("FAIL repeat_job_done: got %0d want 1", job_done); end
      end
    end
    repeat (3) tick();
    n_checks++; if (edges !== 3) begin n_fail++; $display("FAIL repeat_edges: got %0d want 3", edges); end
    edges = 0;
    push_job(7'd3, 4'd0, 16'd2);
    tick();
    pulse_done();
    t = 0;
    while (!job_done && t < 20) begin
      t++;
      tick();
    end
    n_checks++; if (job_done !== 1'b1) begin n_fail++; $display("FAIL rep0_done: got %0d want 1", job_done); end
    repeat (3) tick();
    n_checks++; if (edges !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL rep0_edges: got edges=%0d busy=%0d want 1/0", edges, busy); end
  endtask

  task automatic test_fifo_order;
    int t;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_job(7'(10 + k), 4'd1, 16'd1);
      n_checks++; if (fifo_count !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_count_%0d: got %0d want %0d", k, fifo_count, k + 1); end
    end
    n_checks++; if (jif.push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0d want 0", jif.push_ready); end
    push_job(7'd14, 4'd1, 16'd1);
    n_checks++; if (fifo_count !== 3'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL full_drop: got cnt=%0d busy=%0d want 4/0", fifo_count, busy); end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!jif.tx_start && t < 20) begin
        t++;
        tick();
      end
      n_checks++; if (jif.tx_start !== 1'b1 || jif.tx_end_count !== 7'(10 + k)) begin n_fail++; $display("FAIL order_%0d: got start=%0d end=%0d want 1/%0d", k, jif.tx_start, jif.tx_end_count, 10 + k); end
      if (k == 0) begin
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL order_count: got %0d want 3", fifo_count); end
      end
      pulse_done();
      t = 0;
      while (!job_done && t < 20) begin
        t++;
        tick();
      end
      n_checks++; if (job_done !== 1'b1 || irq !== (k == 3)) begin n_fail++; $display("FAIL order_irq_%0d: got jd=%0d irq=%0d want 1/%0d", k, job_done, irq, (k == 3)); end
    end
    repeat (4) tick();
    n_checks++; if (jif.tx_start !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL order_drained: got start=%0d cnt=%0d busy=%0d want 0/0/0", jif.tx_start, fifo_count, busy); end
  endtask

  task automatic test_back_to_back;
    int low;
    int t;
    logic saw_done;
    enable = 1'b0;
    push_job(7'd40, 4'd1, 16'd2);
    push_job(7'd41, 4'd1, 16'd2);
    enable = 1'b1;
    tick();
    n_checks++; if (jif.tx_start !== 1'b1 || jif.tx_end_count !== 7'd40) begin n_fail++; $display("FAIL b2b_first: got start=%0d end=%0d want 1/40", jif.tx_start, jif.tx_end_count); end
    pulse_done();
    low = 0;
    saw_done = 1'b0;
    while (!jif.tx_start && low < 20) begin
      low++;
      tick();
      if (job_done) saw_done = 1'b1;
    end
    n_checks++; if (low !== 4 || saw_done !== 1'b1) begin n_fail++; $display("FAIL b2b_low: got low=%0d jd=%0d want 4/1", low, saw_done); end
    n_checks++; if (jif.tx_end_count !== 7'd41) begin n_fail++; $display("FAIL b2b_second: got %0d want 41", jif.tx_end_count); end
    pulse_done();
    t = 0;
    while (!job_done && t < 20) begin
      t++;
      tick();
    end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq: got %0d want 1", irq); end
  endtask

  task automatic test_abort;
    logic seen_jd;
    enable = 1'b0;
    push_job(7'd20, 4'd2, 16'd5);
    push_job(7'd21, 4'd2, 16'd5);
    push_job(7'd22, 4'd2, 16'd5);
    enable = 1'b1;
    tick();
    n_checks++; if (jif.tx_start !== 1'b1 || fifo_count !== 3'd2) begin n_fail++; $display("FAIL abort_pre: got start=%0d cnt=%0d want 1/2", jif.tx_start, fifo_count); end
    abort = 1'b1;
    jif.push_valid = 1'b1;
    jif.push_end = 7'd23;
    #1;
    n_checks++; if (jif.push_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %0d want 0", jif.push_ready); end
    tick();
    abort = 1'b0;
    jif.push_valid = 1'b0;
    n_checks++; if (jif.tx_start !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_flush: got start=%0d cnt=%0d busy=%0d want 0/0/0", jif.tx_start, fifo_count, busy); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL abort_irq: got %0d want 1", irq); end
    seen_jd = 1'b0;
    repeat (8) begin
      if (job_done) seen_jd = 1'b1;
      tick();
    end
    n_checks++; if (seen_jd !== 1'b0 || fifo_count !== 3'd0 || jif.tx_start !== 1'b0) begin n_fail++; $display("FAIL abort_after: got jd=%0d cnt=%0d start=%0d want 0/0/0", seen_jd, fifo_count, jif.tx_start); end
  endtask

  task automatic test_irq_clr;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear1: got %0d want 0", irq); end
    push_job(7'd50, 4'd1, 16'd0);
    tick();
    pulse_done();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    n_checks++; if (job_done !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got jd=%0d irq=%0d want 1/1", job_done, irq); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear2: got %0d want 0", irq); end
  endtask

  task automatic test_reset_mid;
    push_job(7'd33, 4'd1, 16'd10);
    tick();
    pulse_done();
    tick();
    tick();
    n_checks++; if (busy !== 1'b1 || jif.tx_end_count !== 7'd33) begin n_fail++; $display("FAIL mid_gap: got busy=%0d end=%0d want 1/33", busy, jif.tx_end_count); end
    rst = 1'b1;
    #2;
    n_checks++; if (busy !== 1'b0 || jif.tx_end_count !== 7'd0 || jif.tx_start !== 1'b0) begin n_fail++; $display("FAIL async_rst: got busy=%0d end=%0d start=%0d want 0/0/0", busy, jif.tx_end_count, jif.tx_start); end
    n_checks++; if (fifo_count !== 3'd0 || job_done !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL async_rst2: got cnt=%0d jd=%0d irq=%0d want 0/0/0", fifo_count, job_done, irq); end
    rst = 1'b0;
    jif.tx_done = 1'b1;
    tick();
    jif.tx_done = 1'b0;
    tick();
    n_checks++; if (jif.tx_start !== 1'b0 || busy !== 1'b0 || job_done !== 1'b0) begin n_fail++; $display("FAIL idle_tx_done: got start=%0d busy=%0d jd=%0d want 0/0/0", jif.tx_start, busy, job_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    abort = 1'b0;
    irq_clr = 1'b0;
    jif.push_valid = 1'b0;
    jif.push_end = '0;
    jif.push_rep = '0;
    jif.push_gap = '0;
    jif.tx_done = 1'b0;
    test_reset();
    test_single();
    test_repeat();
    test_fifo_order();
    test_back_to_back();
    test_abort();
    test_irq_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
